// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues one outstanding memory read
// at a time and buffers up to two fetched words for the decoder.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        halt,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        mem_re,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_data_r,
  input  logic        mem_rdy,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  // Handshakes: a memory read completes on any edge where mem_re && mem_rdy
  // (mem_rdy is ignored while mem_re is low, and mem_addr holds until completion);
  // the decoder takes the head entry on any edge where instr_valid && instr_ready.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  count, count_nxt;
  logic [31:0] word1, addr1;
  logic [31:0] pc_nxt, addr_nxt;
  logic        complete, push, pop, can_issue;

  assign dbg_state = state;

  always_comb begin
    complete  = mem_re & mem_rdy;
    pop       = instr_valid & instr_ready & ~redirect;
    push      = (state == S_REQ) & complete & ~redirect;
    count_nxt = count;
    if (redirect)
      count_nxt = 2'd0;
    else if (push & ~pop)
      count_nxt = count + 2'd1;
    else if (pop & ~push)
      count_nxt = count - 2'd1;
    pc_nxt = pc;
    if (redirect)
      pc_nxt = redirect_pc;
    else if (push)
      pc_nxt = pc + PC_STEP;
    can_issue = en & ~halt & (count_nxt < 2'd2);
    state_nxt = state;
    addr_nxt  = mem_addr;
    case (state)
      S_IDLE: begin
        if (!redirect && can_issue) begin
          state_nxt = S_REQ;
          addr_nxt  = pc_nxt;
        end
      end
      S_REQ: begin
        // A redirect with completion drops the word; the new stream starts a cycle later.
        if (redirect)
          state_nxt = complete ? S_IDLE : S_DISCARD;
        else if (complete) begin
          if (can_issue)
            addr_nxt = pc_nxt;
          else
            state_nxt = S_IDLE;
        end
      end
      S_DISCARD: begin
        if (complete) begin
          if (!redirect && can_issue) begin
            state_nxt = S_REQ;
            addr_nxt  = pc_nxt;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      count       <= 2'd0;
      mem_re      <= 1'b0;
      busy        <= 1'b0;
      mem_addr    <= RESET_PC;
      pc          <= RESET_PC;
      instr       <= 32'h0;
      instr_pc    <= 32'h0;
      instr_valid <= 1'b0;
      word1       <= 32'h0;
      addr1       <= 32'h0;
    end else begin
      state       <= state_nxt;
      count       <= count_nxt;
      mem_re      <= (state_nxt != S_IDLE);
      busy        <= (state_nxt != S_IDLE);
      mem_addr    <= addr_nxt;
      pc          <= pc_nxt;
      instr_valid <= (count_nxt != 2'd0);
      // Two-entry shift FIFO: instr/instr_pc are the head, word1/addr1 the tail.
      if (!redirect) begin
        case ({push, pop})
          2'b10: begin
            if (count == 2'd0) begin
              instr    <= mem_data_r;
              instr_pc <= mem_addr;
            end else begin
              word1 <= mem_data_r;
              addr1 <= mem_addr;
            end
          end
          2'b01: begin
            instr    <= word1;
            instr_pc <= addr1;
          end
          2'b11: begin
            if (count == 2'd1) begin
              instr    <= mem_data_r;
              instr_pc <= mem_addr;
            end else begin
              instr    <= word1;
              instr_pc <= addr1;
              word1    <= mem_data_r;
              addr1    <= mem_addr;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic, checked against
// an in-order address-stream model and a latency-configurable memory responder.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0, halt = 1'b0, redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        mem_re;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_r = 32'h0;
  logic        mem_rdy = 1'b0;
  logic [31:0] instr, instr_pc, pc;
  logic        instr_valid, busy;
  logic        instr_ready = 1'b0;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0), .PC_STEP(32'd4)) dut (
    .clk(clk), .rst(rst), .en(en), .halt(halt), .redirect(redirect),
    .redirect_pc(redirect_pc), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_data_r(mem_data_r), .mem_rdy(mem_rdy), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .pc(pc), .busy(busy),
    .dbg_state(dbg_state)
  );

  int n_assert = 0;
  int n_fail = 0;

  // memory responder state
  bit          man_mode = 1'b0, man_rdy = 1'b0, rand_lat = 1'b0;
  int          lat_cfg = 0, wait_left = 0, n_cmpl = 0, n_pop = 0;
  bit          req_active = 1'b0;
  logic [31:0] last_cmpl = 32'h0;

  // scoreboard state: next address the decoder must receive
  logic [31:0] exp_pop = 32'h0;
  logic [31:0] exp_q[$];
  logic        pre_valid, pre_ready, pre_re, pre_rdy, pre_redir;
  logic [31:0] pre_instr, pre_ipc, pre_addr, pre_rpc;

  function automatic logic [31:0] fdat(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string p);
    chk({p, "_mem_re"}, mem_re, 0);
    chk({p, "_mem_addr"}, mem_addr, 32'h0);
    chk({p, "_pc"}, pc, 32'h0);
    chk({p, "_instr"}, instr, 32'h0);
    chk({p, "_instr_pc"}, instr_pc, 32'h0);
    chk({p, "_valid"}, instr_valid, 0);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_state"}, dbg_state, 0);
  endtask

  task automatic mem_drive();
    if (mem_re === 1'b1) begin
      if (!req_active) begin
        req_active = 1'b1;
        wait_left  = rand_lat ? int'($urandom_range(0, 3)) : lat_cfg;
      end
      mem_rdy = man_mode ? man_rdy : (wait_left == 0);
    end else begin
      mem_rdy = 1'b0;
    end
    mem_data_r = mem_rdy ? fdat(mem_addr) : $urandom;
  endtask

  // One clock: respond to memory, capture pre-edge view, advance, check after the edge.
  task automatic cyc();
    mem_drive();
    pre_valid = instr_valid; pre_ready = instr_ready; pre_instr = instr; pre_ipc = instr_pc;
    pre_re = mem_re; pre_rdy = mem_rdy; pre_addr = mem_addr;
    pre_redir = redirect; pre_rpc = redirect_pc;
    @(posedge clk); #1;
    if (pre_re && pre_rdy) begin
      req_active = 1'b0;
      n_cmpl++;
      last_cmpl = pre_addr;
    end else if (pre_re && wait_left > 0) begin
      wait_left--;
    end
    if (!pre_re) req_active = 1'b0;
    if (pre_redir) begin
      exp_pop = pre_rpc;
      chk("redir_flush", instr_valid, 0);
      chk("redir_pc", pc, pre_rpc);
    end else if (pre_valid && pre_ready) begin
      chk("pop_pc", pre_ipc, exp_pop);
      chk("pop_data", pre_instr, fdat(exp_pop));
      exp_pop += 32'd4;
      n_pop++;
    end
    if (pre_re && !pre_rdy) begin
      chk("hold_re", mem_re, 1);
      chk("hold_addr", mem_addr, pre_addr);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; en = 1'b0; halt = 1'b0; redirect = 1'b0; instr_ready = 1'b0;
    mem_rdy = 1'b0; man_mode = 1'b0; man_rdy = 1'b0; rand_lat = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_pop = 32'h0; req_active = 1'b0; wait_left = 0; n_cmpl = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int c0;
    // reset values, then zero-wait streaming
    do_reset();
    check_reset_vals("rst");
    lat_cfg = 0; instr_ready = 1'b1; en = 1'b1;
    cyc();
    chk("t1_re0", mem_re, 1);
    chk("t1_addr0", mem_addr, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      chk("t1_re", mem_re, 1);
      chk("t1_addr", mem_addr, 32'(4 * k));
      chk("t1_valid", instr_valid, 1);
      chk("t1_ipc", instr_pc, 32'(4 * (k - 1)));
    end

    // decoder stalled, 2-cycle memory: FIFO fills with 0 and 4
    do_reset();
    lat_cfg = 1; instr_ready = 1'b0; en = 1'b1;
    cyc();
    n = 0;
    while (mem_re && n < 20) begin cyc(); n++; end
    chk("t2_re", mem_re, 0);
    chk("t2_pc", pc, 32'h8);
    chk("t2_pushes", n_cmpl, 2);
    chk("t2_head", instr_pc, 32'h0);
    repeat (3) cyc();
    chk("t2_idle", mem_re, 0);
    lat_cfg = 2; instr_ready = 1'b1;
    cyc();
    instr_ready = 1'b0;
    chk("t2_reissue_re", mem_re, 1);
    chk("t2_reissue_addr", mem_addr, 32'h8);
    chk("t2_head4", instr_pc, 32'h4);

    // redirect while the request at 0x8 waits
    redirect = 1'b1; redirect_pc = 32'h100;
    cyc();
    redirect = 1'b0;
    chk("t3_state_discard", dbg_state, 2);
    chk("t3_old_addr", mem_addr, 32'h8);
    c0 = n_cmpl; n = 0;
    while (n_cmpl == c0 && n < 10) begin cyc(); n++; end
    chk("t3_discard_done", n_cmpl, c0 + 1);
    chk("t3_new_addr", mem_addr, 32'h100);
    chk("t3_state_req", dbg_state, 1);
    chk("t3_dropped", instr_valid, 0);
    lat_cfg = 0; instr_ready = 1'b1; n = 0;
    while (!instr_valid && n < 10) begin cyc(); n++; end
    chk("t3_first_ipc", instr_pc, 32'h100);

    // halt with the request at 0x10 outstanding
    do_reset();
    lat_cfg = 1; instr_ready = 1'b1; en = 1'b1; n = 0;
    while (!(mem_re === 1'b1 && mem_addr === 32'h10) && n < 40) begin cyc(); n++; end
    chk("t4_reach", mem_addr, 32'h10);
    halt = 1'b1; n = 0;
    while (mem_re && n < 10) begin cyc(); n++; end
    chk("t4_re", mem_re, 0);
    chk("t4_pc", pc, 32'h14);
    chk("t4_last", last_cmpl, 32'h10);
    repeat (3) cyc();
    chk("t4_stay", mem_re, 0);
    halt = 1'b0;
    cyc();
    chk("t4_resume_re", mem_re, 1);
    chk("t4_resume_addr", mem_addr, 32'h14);

    // address wrap
    lat_cfg = 0; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cyc();
    redirect = 1'b0;
    exp_q = '{32'hFFFF_FFFC, 32'h0, 32'h4};
    for (int k = 0; k < 12; k++) begin
      cyc();
      if (instr_valid && exp_q.size() > 0) chk("t5_ipc", instr_pc, exp_q.pop_front());
    end
    chk("t5_done", exp_q.size(), 0);

    // redirect together with mem_rdy and instr_ready at count 1
    do_reset();
    man_mode = 1'b1; man_rdy = 1'b0; en = 1'b1;
    cyc();
    man_rdy = 1'b1;
    cyc();
    man_rdy = 1'b0;
    cyc();
    chk("t6_count1", instr_valid, 1);
    chk("t6_addr4", mem_addr, 32'h4);
    man_rdy = 1'b1; instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
    cyc();
    man_rdy = 1'b0; instr_ready = 1'b0; redirect = 1'b0;
    cyc();
    chk("t6_nopush", instr_valid, 0);
    chk("t6_pc", pc, 32'h200);
    chk("t6_new_re", mem_re, 1);
    chk("t6_new_addr", mem_addr, 32'h200);
    // asynchronous reset in the middle of the request at 0x200
    #2;
    rst = 1'b0; mem_rdy = 1'b0;
    #1;
    check_reset_vals("mid_rst");

    // randomized traffic against the stream model
    do_reset();
    rand_lat = 1'b1; n_pop = 0;
    for (int i = 0; i < 1500; i++) begin
      en          = ($urandom_range(0, 9) != 0);
      halt        = ($urandom_range(0, 9) == 0);
      instr_ready = $urandom_range(0, 1);
      redirect    = ($urandom_range(0, 39) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      cyc();
    end
    redirect = 1'b0;
    chk("rand_progress", (n_pop > 100), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage between `program_counter`/`memory` and `decoder`. It owns the fetch address and issues single-outstanding read requests on the `memory` rdy handshake. It buffers up to two fetched words in a FIFO and presents them to the decoder with a valid/ready handshake. It supports redirect (flush and restart at a new PC) and halt (stop issuing requests).

## Interface
- `RESET_PC`, 32'h0000_0000: fetch address after reset.
- `PC_STEP`, 4: increment per fetched word. Arithmetic is modulo 2^32.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  fetch enable. While low, no new requests start.
- `halt`  in  1  level input. While high, no new requests start.
- `redirect`  in  1  one-cycle pulse: flush the buffer and restart at `redirect_pc`.
- `redirect_pc`  in  32  new fetch address, sampled when `redirect`=1.
- `mem_re`  out  1  read request to `memory`.
- `mem_addr`  out  32  read address. Stable while `mem_re`=1 and `mem_rdy`=0.
- `mem_data_r`  in  32  read data. Valid when `mem_re`=1 and `mem_rdy`=1.
- `mem_rdy`  in  1  completion of the current request.
- `instr`  out  32  instruction word at the FIFO head.
- `instr_pc`  out  32  address of `instr`.
- `instr_valid`  out  1  FIFO non-empty.
- `instr_ready`  in  1  decoder accepts the head entry.
- `pc`  out  32  next address to fetch.
- `busy`  out  1  a request is outstanding (state REQ or DISCARD).

## Operation
- **FIFO:** 2 entries, each {word, addr}. Head drives `instr`/`instr_pc`. `instr_valid` = (count != 0).
- **Pop:** occurs when `instr_valid` & `instr_ready`.
- **Push:** occurs on a completed request in REQ.
- **Memory handshake:** one request outstanding at a time.
  - A request completes in the cycle where `mem_re`=1 and `mem_rdy`=1. `mem_rdy` is permitted in the first cycle of `mem_re`.
  - `mem_rdy` is ignored while `mem_re`=0.
- **States:**
  - IDLE: `mem_re`=0. Go to REQ when `en` & !`halt` & count<2. On entry to REQ, `mem_addr`<=`pc` and `mem_re`<=1.
  - REQ: hold the request until `mem_rdy`. On completion:
    - push {`mem_data_r`, `mem_addr`} and set `pc`<=`pc`+`PC_STEP`.
    - If `en` & !`halt` & post-edge count<2, stay in REQ with `mem_addr`<=new `pc` (back-to-back). Otherwise go to IDLE.
  - DISCARD: keep `mem_re`=1 on the old address until `mem_rdy`. Drop the returned data, with no push and no `pc` change. Then go to REQ (if enabled) or IDLE.
- **Redirect** (highest priority):
  - FIFO is cleared and `pc`<=`redirect_pc`. A pop in the same cycle is void.
  - REQ without `mem_rdy` in that cycle → DISCARD.
  - REQ with `mem_rdy` in that cycle → data dropped; next state follows the IDLE rules using `redirect_pc`.
  - IDLE → IDLE. A new request starts the next cycle if enabled.
  - DISCARD → DISCARD.
- **`halt` / `en` low:** block new requests only.
  - An outstanding request still completes and pushes.
  - The FIFO keeps draining.
  - A redirect while halted updates `pc`; the block stays idle until `halt`=0.
- **Push and pop in the same cycle:** count is unchanged. Overflow cannot occur, because a request starts only when count<2.
- **Reset:** asserting `rst` mid-request aborts the request immediately.
  - The memory sees `mem_re` drop.
  - The bench must tolerate the abandoned access.

## Timing
- **Reset values:**
  - `mem_re`=0, `mem_addr`=`RESET_PC`, `pc`=`RESET_PC`.
  - `instr`=0, `instr_pc`=0, `instr_valid`=0, `busy`=0.
  - State IDLE, count 0.
- **All outputs are registered.**
- **Cycle 0** = first edge with `en`=1 in IDLE. `mem_re` rises after that edge.
- **Push latency:** `mem_rdy` sampled high at edge N → entry visible and `instr_valid`=1 after edge N.
- **Zero-wait memory** (`mem_rdy`=`mem_re`) with `instr_ready`=1 constantly: one word per cycle, and `mem_re` stays high continuously.
- **Redirect at edge R:** `instr_valid`=0 after R. The first new request is issued after R+1, or after the DISCARD completion edge.
- **Address wrap:** 32'hFFFF_FFFC + 4 → 32'h0000_0000. No fault is raised.

## Test plan
- **Reset then `en`=1, zero-wait memory, `instr_ready`=1:**
  - `mem_addr` sequence 0, 4, 8, 12 on consecutive cycles.
  - `instr_pc` follows one cycle later.
  - `mem_re` never drops.
- **`instr_ready`=0, 2-cycle memory latency:**
  - Exactly two pushes (addresses 0 and 4), then `mem_re`=0 and `pc`=8.
  - Raising `instr_ready` for one cycle pops 0 and re-issues at 8.
- **Redirect to 0x100 while a request at 0x8 is waiting (`mem_rdy` returns 2 cycles later):**
  - State goes to DISCARD and the 0x8 data is dropped.
  - FIFO empty the cycle after redirect.
  - Next `mem_addr`=0x100, and the first `instr_pc`=0x100.
- **`halt` raised while the request at 0x10 is outstanding:**
  - 0x10 completes and is pushed, then `mem_re`=0 and `pc`=0x14.
  - Releasing `halt` resumes at 0x14.
- **Wrap:** `redirect_pc`=0xFFFF_FFFC with zero-wait memory → `instr_pc` sequence 0xFFFF_FFFC, 0x0, 0x4.
- **Simultaneous events and mid-request reset:**
  - `redirect` together with `mem_rdy` and `instr_ready` at count=1: FIFO empty, no push, `pc`=`redirect_pc`.
  - `rst` asserted mid-request: all outputs return to their reset values asynchronously.
